multicycle_controller: RTL and testbench

//  Moore FSM + ALU/imm decoders sequencing the multicycle RV32I datapath (shared instr/data memory, IR/OldPC/A/Data/ALUOut regs).

---
 rtl/multicycle_controller_pkg.sv | 43 ++++
 rtl/multicycle_controller_alu_decoder.sv | 19 +
 rtl/multicycle_controller.sv | 129 ++++++++++++
 tb/tb_multicycle_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: state codes, opcodes and datapath select encodings for the multicycle RV32I controller
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// mc_alu_decoder: maps ALUOp and instruction funct fields to the ALUControl code
module mc_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  logic [2:0] funct_ctrl;
  // sub only for R-type (op[5]=1); addi with imm[10]=1 must stay an add
  assign funct_ctrl = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                      funct3 == 3'b010 ? ALU_SLT :
                      funct3 == 3'b110 ? ALU_OR :
                      funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign alu_control = alu_op == ALUOP_SUB   ? ALU_SUB :
                       alu_op == ALUOP_FUNCT ? funct_ctrl : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle RV32I datapath (lw/sw/R/I/beq/jal).
// Optional MC_CTRL_MEMREADY_EN adds a MemReady handshake that stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
`ifdef MC_CTRL_MEMREADY_EN
  input  logic               MemReady,
`endif
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic [STATE_W-1:0] State
);
  state_t     state, next;
  logic       ready, pc_update, branch, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;
`ifdef MC_CTRL_MEMREADY_EN
  assign ready = MemReady;
`else
  assign ready = 1'b1;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next      = FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    alu_op    = ALUOP_ADD;
    case (state)
      FETCH: begin
        next      = ready ? DECODE : FETCH;
        ir_write  = ready;
        pc_update = ready;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      DECODE: begin
        next    = (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_RTYPE ? EXECR :
                  op == OP_ITYPE ? EXECI :
                  op == OP_BEQ   ? BEQ :
                  op == OP_JAL   ? JAL : FETCH;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        next    = op == OP_LW ? MEMREAD : MEMWRITE;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        next   = ready ? MEMWB : MEMREAD;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        next      = ready ? FETCH : MEMWRITE;
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        next    = ALUWB;
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        next    = ALUWB;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_A;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        next      = ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_4;
        pc_update = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  // strobes are gated by reset so nothing is written while the FSM is held in FETCH
  assign PCWrite  = reset & (pc_update | (branch & Zero));
  assign MemWrite = reset & mem_write;
  assign IRWrite  = reset & ir_write;
  assign RegWrite = reset & reg_write;
  assign ImmSrc   = op == OP_SW  ? IMM_S :
                    op == OP_BEQ ? IMM_B :
                    op == OP_JAL ? IMM_J : IMM_I;
  assign State    = STATE_W'(state);
  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for multicycle_controller (default build and MC_CTRL_MEMREADY_EN)
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
`ifdef MC_CTRL_MEMREADY_EN
  logic       MemReady = 1'b1;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;
  int         checks = 0;
  int         errors = 0;
  logic [20:0] sb_val[$];
  string       sb_tag[$];

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
`ifdef MC_CTRL_MEMREADY_EN
    .MemReady   (MemReady),
`endif
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .State      (State)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] e(input logic [3:0] st, input logic pcw, input logic adr,
                                    input logic mw, input logic irw, input logic rw,
                                    input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sbv,
                                    input logic [2:0] alu, input logic [2:0] imm);
    return {st, pcw, adr, mw, irw, rw, res, sa, sbv, alu, imm};
  endfunction

  function automatic logic [20:0] fe(input logic on, input logic [2:0] imm);
    return e(4'd0, on, 1'b0, 1'b0, on, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm);
  endfunction

  function automatic logic [20:0] de(input logic [2:0] imm);
    return e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
  endfunction

  function automatic logic [20:0] wb(input logic [2:0] imm);
    return e(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction

  task automatic chk(input string tag, input logic [20:0] x);
    logic [20:0] got, want;
    string t;
    sb_val.push_back(x);
    sb_tag.push_back(tag);
    #1;
    got  = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
    want = sb_val.pop_front();
    t    = sb_tag.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, got, want);
    end
  endtask

  task automatic cyc(input string tag, input logic [20:0] x);
    chk(tag, x);
    @(negedge clk);
  endtask

  task automatic rtype(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [3:0] st, input logic [1:0] sbv, input logic [2:0] alu);
    op = o; funct3 = f3; funct7b5 = f7;
    cyc({tag, "_fetch"}, fe(1'b1, 3'b000));
    cyc({tag, "_decode"}, de(3'b000));
    cyc({tag, "_exec"}, e(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sbv, alu, 3'b000));
    cyc({tag, "_aluwb"}, wb(3'b000));
  endtask

  task automatic beq(input string tag, input logic z);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc({tag, "_fetch"}, fe(1'b1, 3'b010));
    cyc({tag, "_decode"}, de(3'b010));
    Zero = z;
    cyc({tag, "_beq"}, e(4'd9, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010));
    Zero = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("reset_hold", fe(1'b0, 3'b000));
    reset = 1'b1;
    cyc("lw_fetch", fe(1'b1, 3'b000));
    cyc("lw_decode", de(3'b000));
    cyc("lw_memadr", e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
    cyc("lw_memread", e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    cyc("lw_memwb", e(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
    rtype("r_sub", 7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001);
    rtype("r_add", 7'b0110011, 3'b000, 1'b0, 4'd6, 2'b00, 3'b000);
    rtype("r_slt", 7'b0110011, 3'b010, 1'b0, 4'd6, 2'b00, 3'b101);
    rtype("i_add_f7", 7'b0010011, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000);
    rtype("i_or", 7'b0010011, 3'b110, 1'b0, 4'd7, 2'b01, 3'b011);
    rtype("i_and", 7'b0010011, 3'b111, 1'b0, 4'd7, 2'b01, 3'b010);
    rtype("i_xor_dflt", 7'b0010011, 3'b100, 1'b0, 4'd7, 2'b01, 3'b000);
    beq("beq_taken", 1'b1);
    beq("beq_not", 1'b0);
    op = 7'b1101111;
    cyc("jal_fetch", fe(1'b1, 3'b011));
    cyc("jal_decode", de(3'b011));
    Zero = 1'b1;
    cyc("jal_jal", e(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011));
    cyc("jal_aluwb", wb(3'b011));
    Zero = 1'b0;
    op = 7'b0100011;
    cyc("sw_fetch", fe(1'b1, 3'b001));
    cyc("sw_decode", de(3'b001));
    cyc("sw_memadr", e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001));
`ifdef MC_CTRL_MEMREADY_EN
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("sw_memwrite_wait", e(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001));
    MemReady = 1'b1;
`endif
    cyc("sw_memwrite", e(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001));
`ifdef MC_CTRL_MEMREADY_EN
    op = 7'b0000011;
    MemReady = 1'b0;
    cyc("fetch_stall0", fe(1'b0, 3'b000));
    cyc("fetch_stall1", fe(1'b0, 3'b000));
    MemReady = 1'b1;
    cyc("fetch_ready", fe(1'b1, 3'b000));
    cyc("stall_decode", de(3'b000));
    cyc("stall_memadr", e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
    MemReady = 1'b0;
    cyc("memread_stall", e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    MemReady = 1'b1;
    cyc("memread_ready", e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    cyc("stall_memwb", e(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
`endif
    op = 7'b0000011;
    cyc("rst_fetch", fe(1'b1, 3'b000));
    cyc("rst_decode", de(3'b000));
    cyc("rst_memadr", e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
    cyc("rst_memread", e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    chk("rst_memwb", e(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
    reset = 1'b0;
    cyc("rst_async", fe(1'b0, 3'b000));
    reset = 1'b1;
    op = 7'b0000000;
    cyc("nop_fetch", fe(1'b1, 3'b000));
    cyc("nop_decode", de(3'b000));
    cyc("nop_fetch2", fe(1'b1, 3'b000));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
